// File: rtl/apb_requester_if.sv
// Command/response port and APB3 bus of apb_requester grouped in one interface.
// master: the requester side; slave: local controller plus APB completer side.
interface apb_requester_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              busy;

    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        input  rsp_ready,
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout, busy,
        output rsp_ready,
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_requester.sv
// APB3 requester: one command at a time, SETUP/ACCESS on APB, response on valid/ready.
// Optional ACCESS watchdog enabled by defining APB_TIMEOUT_EN.
module apb_requester #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               pclk,
    input  logic               presetn,
    apb_requester_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("apb_requester: TIMEOUT_CYC must be >= 1");
    end

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              cmd_ready;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_timeout_q, rsp_timeout_d;
`endif

    // Command slot reopens in the same cycle the pending response is consumed.
    assign cmd_ready = presetn && (state_q == IDLE) && (!rsp_valid_q || bus.rsp_ready);

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_TIMEOUT_EN
        cnt_d         = cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif

        if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = '0;
`ifdef APB_TIMEOUT_EN
            rsp_timeout_d = 1'b0;
`endif
        end

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready) begin
                    paddr_d  = bus.cmd_addr;
                    pwrite_d = bus.cmd_write;
                    pwdata_d = bus.cmd_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            ACCESS: begin
                if (bus.pready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.pslverr;
                    rsp_rdata_d = (pwrite_q || bus.pslverr) ? '0 : bus.prdata;
`ifdef APB_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
                    state_d       = IDLE;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q         <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
    assign bus.rsp_timeout = rsp_timeout_q;
`else
    assign bus.rsp_timeout = 1'b0;
`endif

    // psel/penable decode from state so an async reset drops them at once.
    assign bus.psel      = (state_q != IDLE);
    assign bus.penable   = (state_q == ACCESS);
    assign bus.busy      = (state_q != IDLE);
    assign bus.cmd_ready = cmd_ready;
    assign bus.paddr     = paddr_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule
